// File: rtl/dec_frame_packer.sv
// Packs decimated samples into frames: header {HDR_TAG, seq}, FRAME_LEN payload words, XOR checksum.
// Latency: a frame starts one cycle after FRAME_LEN samples are buffered; output word tracks state with no extra register.
// Backpressure: out_ready=0 holds data_o/state; input has none, so samples arriving into a full FIFO are dropped (sticky overflow).
module dec_frame_packer #(
    parameter int FRAME_LEN = 8,
    parameter int FIFO_DEPTH = 16,
    parameter logic [7:0] HDR_TAG = 8'hA5
) (
    input  logic                          clk_data,
    input  logic                          rst_n,
    input  logic                          data_valid,
    input  logic [13:0]                   data_i,
    output logic [15:0]                   data_o,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_start,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] FRAME_L = LW'(FRAME_LEN);
    localparam logic [LW-1:0] LAST_L  = LW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECK} state_t;

    state_t          state_q, state_d;
    logic [13:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [LW-1:0]   level;
    logic [LW-1:0]   cnt;
    logic [7:0]      seq;
    logic [15:0]     chk;
    logic            ovf;
    logic            push, pop;
    logic [15:0]     head_word, hdr_word;

    assign head_word  = {{2{mem[rd_ptr][13]}}, mem[rd_ptr]};
    assign hdr_word   = {HDR_TAG, seq};
    assign pop        = (state_q == PAYLOAD) && out_ready;
    // A full FIFO still takes a sample when the same cycle frees a slot.
    assign push       = data_valid && ((level != DEPTH_L) || pop);
    assign fifo_level = level;
    assign overflow   = ovf;

    always_comb begin
        state_d     = state_q;
        data_o      = '0;
        out_valid   = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (level >= FRAME_L) state_d = HEADER;
            end
            HEADER: begin
                out_valid   = 1'b1;
                frame_start = 1'b1;
                data_o      = hdr_word;
                if (out_ready) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                out_valid = 1'b1;
                data_o    = head_word;
                if (out_ready && (cnt == LAST_L)) state_d = CHECK;
            end
            CHECK: begin
                out_valid = 1'b1;
                data_o    = chk;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_data) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level   <= '0;
            cnt     <= '0;
            seq     <= '0;
            chk     <= '0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (data_valid && !push) ovf <= 1'b1;
            case (state_q)
                HEADER: if (out_ready) begin
                    chk <= hdr_word;
                    cnt <= '0;
                end
                PAYLOAD: if (out_ready) begin
                    chk <= chk ^ head_word;
                    cnt <= cnt + 1'b1;
                end
                CHECK: if (out_ready) begin
                    chk <= '0;
                    seq <= seq + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_data) begin
        if (push) mem[wr_ptr] <= data_i;
    end
endmodule
